lcd_write_arbiter: RTL and testbench

Two-port arbiter that shares the single LCD byte writer (`lcd_write_cmd_data`, I2C backpack at 0x27) between two byte producers. Typical producers are the `lcd_display` row refresher and a custom-character / command loader. The block does four things:
- picks a requester round-robin;
- registers that requester's byte and command/data flag;
- drives the writer's enable until the writer reports done;
- returns a per-requester acknowledge.

A lock input lets a requester hold the writer across a multi-byte sequence, such as set-DDRAM-address followed by 16 characters, without interleaving.

---
 rtl/lcd_write_arbiter.sv | 165 ++++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD byte writer between two producers,
// with per-port lock for contiguous multi-byte bursts and a transfer timeout.
module lcd_write_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic             clk_1MHz,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       lock,
  input  logic [7:0]       data0,
  input  logic [7:0]       data1,
  input  logic [1:0]       cmd_data_in,
  output logic [1:0]       grant,
  output logic [1:0]       ack,
  output logic             ena_write,
  output logic [7:0]       data,
  output logic             cmd_data,
  input  logic             done_write,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned NPORT  = 2;
  localparam int unsigned BYTE_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state, state_d;
  logic               owner, owner_d;
  logic               last, last_d;
  logic               abort_q, abort_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [NPORT-1:0]   grant_d;
  logic [NPORT-1:0]   ack_d;
  logic               ena_d;
  logic [BYTE_W-1:0]  data_d;
  logic               cmd_d;
  logic               terr_d;
  logic               busy_d;
  logic               load;
  logic               load_port;
  logic               win;

  // Next-state and next-output computation for all registered outputs
  always_comb begin
    state_d   = state;
    owner_d   = owner;
    last_d    = last;
    abort_d   = abort_q;
    cnt_d     = cnt;
    grant_d   = grant;
    ack_d     = '0;
    ena_d     = ena_write;
    data_d    = data;
    cmd_d     = cmd_data;
    terr_d    = 1'b0;
    load      = 1'b0;
    load_port = owner;
    win       = 1'b0;

    case (state)
      IDLE: begin
        if (req != '0) begin
          // Contention goes to the port that did not own the writer last
          win       = (req == 2'b11) ? ~last : req[1];
          load      = 1'b1;
          load_port = win;
          owner_d   = win;
          last_d    = win;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (done_write) begin
          ena_d      = 1'b0;
          ack_d      = NPORT'(2'b01) << owner;
          state_d    = GAP;
        end else if (cnt == CNT_LAST) begin
          ena_d   = 1'b0;
          terr_d  = 1'b1;
          abort_d = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        abort_d = 1'b0;
        if (!abort_q && lock[owner]) begin
          if (req[owner]) begin
            load      = 1'b1;
            load_port = owner;
            state_d   = ISSUE;
          end else begin
            state_d = HOLD;
          end
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (req[owner]) begin
          load      = 1'b1;
          load_port = owner;
          state_d   = ISSUE;
        end else if (!lock[owner]) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture the selected port's byte and start a write
    if (load) begin
      grant_d = NPORT'(2'b01) << load_port;
      data_d  = load_port ? data1 : data0;
      cmd_d   = cmd_data_in[load_port];
      cnt_d   = '0;
      ena_d   = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      abort_q     <= 1'b0;
      cnt         <= '0;
      grant       <= '0;
      ack         <= '0;
      ena_write   <= 1'b0;
      data        <= '0;
      cmd_data    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      last        <= last_d;
      abort_q     <= abort_d;
      cnt         <= cnt_d;
      grant       <= grant_d;
      ack         <= ack_d;
      ena_write   <= ena_d;
      data        <= data_d;
      cmd_data    <= cmd_d;
      busy        <= busy_d;
      timeout_err <= terr_d;
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter: requester drivers, a writer model
// with random latency, and a transaction-level ordering model.
module tb_lcd_write_arbiter;

  logic       clk_1MHz = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       lock0 = 1'b0, lock1 = 1'b0;
  logic       cd0 = 1'b0, cd1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       done_write = 1'b0;
  logic [1:0] req, lock, cmd_data_in;
  logic [1:0] grant, ack;
  logic       ena_write, cmd_data, busy, timeout_err;
  logic [7:0] data;

  assign req         = {req1, req0};
  assign lock        = {lock1, lock0};
  assign cmd_data_in = {cd1, cd0};

  lcd_write_arbiter #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk_1MHz(clk_1MHz), .rst(rst), .req(req), .lock(lock),
    .data0(data0), .data1(data1), .cmd_data_in(cmd_data_in),
    .grant(grant), .ack(ack), .ena_write(ena_write), .data(data),
    .cmd_data(cmd_data), .done_write(done_write), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  typedef struct {
    int         port;
    logic [7:0] d;
    logic       cd;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] qd [2][16];
  logic       qc [2][16];
  int         n [2];
  bit         locked [2];
  int         pause [2];
  int         m_last = 1;
  int         hi_cnt = 0, cur_lat = 1, fixed_lat = 0;
  bit         sb_on = 1'b0, writer_on = 1'b1, spur_on = 1'b0;
  logic       prev_ena = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_1MHz);
    #1;
  endtask

  // Writer model plus scoreboard monitor, sampled 1 time unit after each edge
  always @(posedge clk_1MHz) begin
    #1;
    if (ena_write && !prev_ena) begin
      hi_cnt  = 0;
      cur_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 12));
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_issue: got data %0h expected no write", data);
        end else begin
          cur = exp_q.pop_front();
          check("issue_grant", 32'(grant), 32'(2'b01 << cur.port));
        end
      end
    end
    if (ena_write) begin
      hi_cnt++;
      if (sb_on) begin
        check("issue_data", 32'(data), 32'(cur.d));
        check("issue_cmd_data", 32'(cmd_data), 32'(cur.cd));
      end
    end
    if (sb_on && ack != 2'b00) begin
      check("ack_port", 32'(ack), 32'(2'b01 << cur.port));
      check("ena_high_cycles", 32'(hi_cnt), 32'(cur_lat));
      check("no_timeout_on_ack", 32'(timeout_err), 32'd0);
    end
    if (ena_write) done_write = writer_on && (hi_cnt >= cur_lat);
    else           done_write = spur_on && ($urandom_range(0, 1) == 1);
    prev_ena = ena_write;
  end

  task automatic set_req(input int p, input logic v);
    if (p == 0) req0 = v; else req1 = v;
  endtask

  task automatic set_lock(input int p, input logic v);
    if (p == 0) lock0 = v; else lock1 = v;
  endtask

  task automatic set_item(input int p, input int k);
    if (p == 0) begin data0 = qd[0][k]; cd0 = qc[0][k]; end
    else        begin data1 = qd[1][k]; cd1 = qc[1][k]; end
  endtask

  // Expected write order: contention goes to the port that was not last;
  // a locked owner sends its whole queue before anyone else.
  function automatic void model_push();
    int idx [2];
    int owner;
    exp_t e;
    idx[0] = 0;
    idx[1] = 0;
    while (idx[0] < n[0] || idx[1] < n[1]) begin
      if (idx[0] < n[0] && idx[1] < n[1]) owner = (m_last == 0) ? 1 : 0;
      else                                owner = (idx[0] < n[0]) ? 0 : 1;
      do begin
        e.port = owner;
        e.d    = qd[owner][idx[owner]];
        e.cd   = qc[owner][idx[owner]];
        exp_q.push_back(e);
        idx[owner]++;
      end while (locked[owner] && idx[owner] < n[owner]);
      m_last = owner;
    end
  endfunction

  // One requester: holds req until ack, then presents the next byte
  task automatic drive_port(input int p);
    int k = 0;
    int b;
    if (n[p] == 0) return;
    set_item(p, 0);
    set_lock(p, locked[p]);
    set_req(p, 1'b1);
    while (k < n[p]) begin
      b = 0;
      do begin step(); b++; end while (!ack[p] && b < 6000);
      if (!ack[p]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ack_wait port %0d: got no ack expected ack within 6000 cycles", p);
        set_req(p, 1'b0);
        set_lock(p, 1'b0);
        return;
      end
      k++;
      if (k == n[p]) begin
        set_req(p, 1'b0);
        set_lock(p, 1'b0);
      end else begin
        if (locked[p] && pause[p] > 0) begin
          set_req(p, 1'b0);
          repeat (pause[p]) begin
            step();
            check("hold_grant", 32'(grant), 32'(2'b01 << p));
            check("hold_no_ena", 32'(ena_write), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
          end
        end
        set_item(p, k);
        set_req(p, 1'b1);
      end
    end
  endtask

  task automatic run_phase();
    int b = 0;
    model_push();
    fork
      drive_port(0);
      drive_port(1);
    join
    while ((busy || exp_q.size() != 0) && b < 200) begin step(); b++; end
    check("phase_queue_drained", 32'(exp_q.size()), 32'd0);
    check("phase_idle_grant", 32'(grant), 32'd0);
    check("phase_idle_busy", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  task automatic clear_phase();
    for (int p = 0; p < 2; p++) begin
      n[p] = 0;
      locked[p] = 1'b0;
      pause[p] = 0;
    end
  endtask

  task automatic wait_rise(input string name);
    int b = 0;
    while (!ena_write && b < 20) begin step(); b++; end
    if (!ena_write) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got ena_write 0 expected 1 within 20 cycles", name);
    end
  endtask

  task automatic count_high(output int c);
    c = 0;
    while (ena_write && c < 200) begin c++; step(); end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_ena_write"}, 32'(ena_write), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_cmd_data"}, 32'(cmd_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    string s;
    int c;

    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    m_last = 1;
    sb_on = 1'b1;

    // Both ports contend, no locks: strict alternation starting at port 0
    clear_phase();
    n[0] = 2; qd[0][0] = 8'h48; qd[0][1] = 8'h48; qc[0][0] = 1'b1; qc[0][1] = 1'b1;
    n[1] = 2; qd[1][0] = 8'h32; qd[1][1] = 8'h32; qc[1][0] = 1'b1; qc[1][1] = 1'b1;
    run_phase();

    // Single command byte with a 50-cycle writer
    clear_phase();
    n[0] = 1; qd[0][0] = 8'h80; qc[0][0] = 1'b0;
    fixed_lat = 50;
    run_phase();
    fixed_lat = 0;

    // Port 1 locked 16-byte row while port 0 keeps requesting
    clear_phase();
    s = "      2025      ";
    n[1] = 16; locked[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin qd[1][i] = s[i]; qc[1][i] = 1'b1; end
    n[0] = 3;
    for (int i = 0; i < 3; i++) begin qd[0][i] = 8'h40 + 8'(i); qc[0][i] = 1'b0; end
    run_phase();

    // Port 0 locked with 20-cycle request gaps; port 1 pending
    clear_phase();
    n[0] = 3; locked[0] = 1'b1; pause[0] = 20;
    for (int i = 0; i < 3; i++) begin qd[0][i] = 8'hC0 + 8'(i); qc[0][i] = 1'b1; end
    n[1] = 2;
    for (int i = 0; i < 2; i++) begin qd[1][i] = 8'h10 + 8'(i); qc[1][i] = 1'b0; end
    run_phase();

    // Randomized bursts with spurious done outside ISSUE
    for (int r = 0; r < 30; r++) begin
      clear_phase();
      for (int p = 0; p < 2; p++) begin
        n[p]      = int'($urandom_range(0, 6));
        locked[p] = ($urandom_range(0, 2) == 0);
        pause[p]  = locked[p] ? int'($urandom_range(0, 4)) : 0;
        for (int i = 0; i < n[p]; i++) begin
          qd[p][i] = 8'($urandom);
          qc[p][i] = 1'($urandom_range(0, 1));
        end
      end
      spur_on = 1'b1;
      run_phase();
      spur_on = 1'b0;
    end

    // Timeout: writer never completes, lock must be dropped by the arbiter
    sb_on = 1'b0;
    writer_on = 1'b0;
    data0 = 8'hA5; cd0 = 1'b0; lock0 = 1'b1; req0 = 1'b1;
    wait_rise("timeout_rise");
    count_high(c);
    check("timeout_ena_cycles", 32'(c), 32'd64);
    check("timeout_err_pulse", 32'(timeout_err), 32'd1);
    check("timeout_no_ack", 32'(ack), 32'd0);
    step();
    check("timeout_err_one_cycle", 32'(timeout_err), 32'd0);
    check("timeout_lock_released", 32'(grant), 32'd0);
    check("timeout_idle_busy", 32'(busy), 32'd0);

    // Done on the last allowed cycle wins over the timeout
    lock0 = 1'b0;
    writer_on = 1'b1;
    fixed_lat = 64;
    wait_rise("retry_rise");
    check("retry_data", 32'(data), 32'h0000_00A5);
    count_high(c);
    check("boundary_ena_cycles", 32'(c), 32'd64);
    check("boundary_ack", 32'(ack), 32'd1);
    check("boundary_no_timeout", 32'(timeout_err), 32'd0);
    req0 = 1'b0;
    step();
    check("boundary_grant_idle", 32'(grant), 32'd0);
    fixed_lat = 0;

    // Reset 10 cycles into a port-1 write, then contention goes to port 0
    writer_on = 1'b0;
    data1 = 8'h77; cd1 = 1'b1; req1 = 1'b1;
    wait_rise("rst_test_rise");
    check("rst_test_grant", 32'(grant), 32'd2);
    repeat (9) step();
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    data0 = 8'h3C; cd0 = 1'b1; req0 = 1'b1;
    rst = 1'b0;
    step();
    check("post_rst_grant", 32'(grant), 32'd1);
    check("post_rst_data", 32'(data), 32'h0000_003C);
    check("post_rst_cmd_data", 32'(cmd_data), 32'd1);
    check("post_rst_ena", 32'(ena_write), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
